// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, size and byte-enable helpers
// for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } arb_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [3:0] byte_en(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    unique case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << {off[1], 1'b0};
      SZ_W:    be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == SZ_H) && off[0]) ||
           (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: wait-cycle counter; expire flags the
// last allowed cycle without a memory response.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding memory port shared by fetch
// and load/store. Macro DMEM_MISALIGN_CHK_EN faults misaligned data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IfReq,
  input  logic [XLEN-1:0] IfAddr,
  output logic [XLEN-1:0] IfRdata,
  output logic            IfDone,
  input  logic            DmReq,
  input  logic            DmWe,
  input  logic [XLEN-1:0] DmAddr,
  input  logic [XLEN-1:0] DmWdata,
  input  logic [2:0]      DmFunc3,
  output logic [XLEN-1:0] DmRdata,
  output logic            DmDone,
  output logic            DmErr,
  output logic            MemReq,
  output logic            MemWe,
  output logic [XLEN-1:0] MemAddr,
  output logic [XLEN-1:0] MemWdata,
  output logic [3:0]      MemBe,
  input  logic            MemReady,
  input  logic [XLEN-1:0] MemRdata,
  output logic            ArbStall
);

  arb_state_t state, state_nxt;

  logic            req_nxt, we_nxt;
  logic [XLEN-1:0] addr_nxt, wdata_nxt;
  logic [3:0]      be_nxt;
  logic [XLEN-1:0] if_rdata_nxt, dm_rdata_nxt;
  logic            if_done_nxt, dm_done_nxt, dm_err_nxt;
  logic            mis_pend, mis_nxt, misalign;
  logic            if_go, dm_go, expire;
  logic [1:0]      size;
  logic [XLEN-1:0] lane_data;
  logic            unused_bits;

  assign size        = DmFunc3[1:0];
  assign unused_bits = ^{DmFunc3[2], IfAddr[1:0]};

  // A requester still seeing its Done pulse is not re-served.
  assign if_go = IfReq & ~IfDone;
  assign dm_go = DmReq & ~DmDone;

  assign ArbStall = (IfReq & ~IfDone) | (DmReq & ~DmDone);

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = misaligned(size, DmAddr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    unique case (size)
      SZ_B:    lane_data = {(XLEN/8){DmWdata[7:0]}};
      SZ_H:    lane_data = {(XLEN/16){DmWdata[15:0]}};
      default: lane_data = DmWdata;
    endcase
  end

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .load   (state == IDLE),
    .enable ((state != IDLE) && !MemReady),
    .expire (expire)
  );

  always_comb begin
    state_nxt    = state;
    req_nxt      = MemReq;
    we_nxt       = MemWe;
    addr_nxt     = MemAddr;
    wdata_nxt    = MemWdata;
    be_nxt       = MemBe;
    if_rdata_nxt = IfRdata;
    dm_rdata_nxt = DmRdata;
    if_done_nxt  = 1'b0;
    dm_done_nxt  = 1'b0;
    dm_err_nxt   = 1'b0;
    mis_nxt      = mis_pend;
    unique case (state)
      IDLE: begin
        if (dm_go) begin
          state_nxt = DATA;
          mis_nxt   = misalign;
          req_nxt   = ~misalign;
          we_nxt    = DmWe & ~misalign;
          addr_nxt  = {DmAddr[XLEN-1:2], 2'b00};
          wdata_nxt = DmWe ? lane_data : '0;
          be_nxt    = DmWe ? byte_en(size, DmAddr[1:0])
                           : 4'b1111;
        end else if (if_go) begin
          state_nxt = FETCH;
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = {IfAddr[XLEN-1:2], 2'b00};
          wdata_nxt = '0;
          be_nxt    = 4'b1111;
        end
      end
      FETCH: begin
        if (MemReady || expire) begin
          state_nxt    = IDLE;
          req_nxt      = 1'b0;
          we_nxt       = 1'b0;
          if_done_nxt  = 1'b1;
          if_rdata_nxt = MemReady ? MemRdata : XLEN'(NOP);
        end
      end
      DATA: begin
        // A misaligned fault completes without a bus cycle.
        if (mis_pend || MemReady || expire) begin
          state_nxt    = IDLE;
          req_nxt      = 1'b0;
          we_nxt       = 1'b0;
          mis_nxt      = 1'b0;
          dm_done_nxt  = 1'b1;
          dm_err_nxt   = mis_pend || !MemReady;
          dm_rdata_nxt = (!mis_pend && MemReady) ? MemRdata : '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mis_pend <= 1'b0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      MemBe    <= 4'b0000;
      IfRdata  <= XLEN'(NOP);
      DmRdata  <= '0;
      IfDone   <= 1'b0;
      DmDone   <= 1'b0;
      DmErr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      mis_pend <= mis_nxt;
      MemReq   <= req_nxt;
      MemWe    <= we_nxt;
      MemAddr  <= addr_nxt;
      MemWdata <= wdata_nxt;
      MemBe    <= be_nxt;
      IfRdata  <= if_rdata_nxt;
      DmRdata  <= dm_rdata_nxt;
      IfDone   <= if_done_nxt;
      DmDone   <= dm_done_nxt;
      DmErr    <= dm_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with a completion
// scoreboard for mem_port_arbiter (TIMEOUT=4).
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int TMO  = 4;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            IfReq, IfDone;
  logic [XLEN-1:0] IfAddr, IfRdata;
  logic            DmReq, DmWe, DmDone, DmErr;
  logic [XLEN-1:0] DmAddr, DmWdata, DmRdata;
  logic [2:0]      DmFunc3;
  logic            MemReq, MemWe, MemReady;
  logic [XLEN-1:0] MemAddr, MemWdata, MemRdata;
  logic [3:0]      MemBe;
  logic            ArbStall;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  always_comb MemRdata = model(MemAddr);

  mem_port_arbiter #(
    .XLEN(XLEN),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfRdata(IfRdata), .IfDone(IfDone),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWdata(DmWdata),
    .DmFunc3(DmFunc3), .DmRdata(DmRdata), .DmDone(DmDone), .DmErr(DmErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemBe(MemBe), .MemReady(MemReady),
    .MemRdata(MemRdata), .ArbStall(ArbStall)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (MemReq !== 1'b0) $display("FAIL rst_memreq got %0b want 0", MemReq); else passed++;
    checks++; if (MemWe !== 1'b0) $display("FAIL rst_memwe got %0b want 0", MemWe); else passed++;
    checks++; if (MemAddr !== 32'h0 || MemWdata !== 32'h0) $display("FAIL rst_addr_wdata got %h/%h want 0/0", MemAddr, MemWdata); else passed++;
    checks++; if (MemBe !== 4'b0000) $display("FAIL rst_membe got %b want 0000", MemBe); else passed++;
    checks++; if (IfRdata !== NOP_W) $display("FAIL rst_ifrdata got %h want %h", IfRdata, NOP_W); else passed++;
    checks++; if (DmRdata !== 32'h0) $display("FAIL rst_dmrdata got %h want 0", DmRdata); else passed++;
    checks++; if ({IfDone, DmDone, DmErr} !== 3'b000) $display("FAIL rst_pulses got %b want 000", {IfDone, DmDone, DmErr}); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    @(posedge clk); #1;
    IfReq = 1'b1; IfAddr = 32'h100;
    exp_q.push_back('{model(32'h100), 1'b0});
    @(negedge clk);
    checks++; if (MemReq !== 1'b0) $display("FAIL fetch_c0_req got %0b want 0", MemReq); else passed++;
    checks++; if (ArbStall !== 1'b1) $display("FAIL fetch_c0_stall got %0b want 1", ArbStall); else passed++;
    @(negedge clk);
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h100 || MemBe !== 4'hF) $display("FAIL fetch_c1_bus got %0b/%h/%b want 1/100/1111", MemReq, MemAddr, MemBe); else passed++;
    checks++; if (IfDone !== 1'b0) $display("FAIL fetch_c1_done got %0b want 0", IfDone); else passed++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (IfDone !== 1'b1) $display("FAIL fetch_c2_done got %0b want 1", IfDone); else passed++;
    checks++; if (IfRdata !== e.rdata) $display("FAIL fetch_c2_rdata got %h want %h", IfRdata, e.rdata); else passed++;
    checks++; if (MemReq !== 1'b0 || ArbStall !== 1'b0) $display("FAIL fetch_c2_req_stall got %0b/%0b want 0/0", MemReq, ArbStall); else passed++;
    @(posedge clk); #1;
    IfReq = 1'b0;
    @(negedge clk);
    checks++; if (MemReq !== 1'b0 || IfDone !== 1'b0) $display("FAIL fetch_nodup got %0b/%0b want 0/0", MemReq, IfDone); else passed++;
  endtask

  task automatic test_priority();
    exp_t e;
    @(posedge clk); #1;
    IfReq = 1'b1; IfAddr = 32'h104;
    DmReq = 1'b1; DmWe = 1'b0; DmAddr = 32'h2000; DmFunc3 = 3'b000;
    exp_q.push_back('{model(32'h2000), 1'b0});
    exp_q.push_back('{model(32'h104), 1'b0});
    @(negedge clk);
    @(negedge clk);
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h2000 || MemWe !== 1'b0) $display("FAIL prio_c1_data got %0b/%h/%0b want 1/2000/0", MemReq, MemAddr, MemWe); else passed++;
    checks++; if (MemBe !== 4'hF) $display("FAIL prio_load_be got %b want 1111", MemBe); else passed++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (DmDone !== 1'b1 || DmErr !== 1'b0) $display("FAIL prio_c2_dmdone got %0b/%0b want 1/0", DmDone, DmErr); else passed++;
    checks++; if (DmRdata !== e.rdata) $display("FAIL prio_c2_dmrdata got %h want %h", DmRdata, e.rdata); else passed++;
    checks++; if (IfDone !== 1'b0 || MemReq !== 1'b0) $display("FAIL prio_c2_idle got %0b/%0b want 0/0", IfDone, MemReq); else passed++;
    @(posedge clk); #1;
    DmReq = 1'b0;
    @(negedge clk);
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h104) $display("FAIL prio_c3_fetch got %0b/%h want 1/104", MemReq, MemAddr); else passed++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (IfDone !== 1'b1 || IfRdata !== e.rdata) $display("FAIL prio_c4_ifdone got %0b/%h want 1/%h", IfDone, IfRdata, e.rdata); else passed++;
    @(posedge clk); #1;
    IfReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_lanes();
    logic [31:0] t_addr [3]  = '{32'h2003, 32'h2002, 32'h2004};
    logic [31:0] t_wdat [3]  = '{32'h0000_00AB, 32'h0000_1234, 32'hDEAD_BEEF};
    logic [2:0]  t_f3   [3]  = '{3'b000, 3'b001, 3'b010};
    logic [3:0]  t_be   [3]  = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] t_lane [3]  = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF};
    logic [31:0] t_word [3]  = '{32'h2000, 32'h2000, 32'h2004};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      DmReq = 1'b1; DmWe = 1'b1; DmAddr = t_addr[i];
      DmWdata = t_wdat[i]; DmFunc3 = t_f3[i];
      exp_q.push_back('{model(t_word[i]), 1'b0});
      @(negedge clk);
      @(negedge clk);
      checks++; if (MemAddr !== t_word[i] || MemWe !== 1'b1) $display("FAIL store%0d_addr got %h/%0b want %h/1", i, MemAddr, MemWe, t_word[i]); else passed++;
      checks++; if (MemBe !== t_be[i]) $display("FAIL store%0d_be got %b want %b", i, MemBe, t_be[i]); else passed++;
      checks++; if (MemWdata !== t_lane[i]) $display("FAIL store%0d_wdata got %h want %h", i, MemWdata, t_lane[i]); else passed++;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (DmDone !== 1'b1 || DmErr !== e.err || DmRdata !== e.rdata) $display("FAIL store%0d_done got %0b/%0b/%h want 1/%0b/%h", i, DmDone, DmErr, DmRdata, e.err, e.rdata); else passed++;
      @(posedge clk); #1;
      DmReq = 1'b0; DmWe = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   req_cyc;
    bit   got;
    MemReady = 1'b0;
    @(posedge clk); #1;
    DmReq = 1'b1; DmWe = 1'b0; DmAddr = 32'h3000; DmFunc3 = 3'b010;
    exp_q.push_back('{32'h0, 1'b1});
    req_cyc = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (DmDone === 1'b1) got = 1;
      else if (MemReq === 1'b1) req_cyc++;
    end
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1) $display("FAIL tmo_data_done got %0b want 1", got); else passed++;
    checks++; if (req_cyc != TMO) $display("FAIL tmo_data_wait got %0d want %0d", req_cyc, TMO); else passed++;
    checks++; if (DmErr !== e.err || DmRdata !== e.rdata || MemReq !== 1'b0) $display("FAIL tmo_data_result got %0b/%h/%0b want %0b/%h/0", DmErr, DmRdata, MemReq, e.err, e.rdata); else passed++;
    @(posedge clk); #1;
    DmReq = 1'b0;
    @(negedge clk);
    checks++; if (DmDone !== 1'b0 || DmErr !== 1'b0) $display("FAIL tmo_pulse_width got %0b/%0b want 0/0", DmDone, DmErr); else passed++;
    @(posedge clk); #1;
    IfReq = 1'b1; IfAddr = 32'h200;
    exp_q.push_back('{NOP_W, 1'b0});
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (IfDone === 1'b1) got = 1;
    end
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || IfRdata !== e.rdata) $display("FAIL tmo_fetch got %0b/%h want 1/%h", got, IfRdata, e.rdata); else passed++;
    @(posedge clk); #1;
    IfReq = 1'b0; MemReady = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_misalign();
    exp_t e;
    @(posedge clk); #1;
    DmReq = 1'b1; DmWe = 1'b1; DmAddr = 32'h2002;
    DmWdata = 32'h1122_3344; DmFunc3 = 3'b010;
`ifdef DMEM_MISALIGN_CHK_EN
    exp_q.push_back('{32'h0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    checks++; if (MemReq !== 1'b0) $display("FAIL mis_noreq got %0b want 0", MemReq); else passed++;
`else
    exp_q.push_back('{model(32'h2000), 1'b0});
    @(negedge clk);
    @(negedge clk);
    checks++; if (MemReq !== 1'b1 || MemBe !== 4'hF || MemAddr !== 32'h2000) $display("FAIL mis_access got %0b/%b/%h want 1/1111/2000", MemReq, MemBe, MemAddr); else passed++;
`endif
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (DmDone !== 1'b1 || DmErr !== e.err || DmRdata !== e.rdata) $display("FAIL mis_done got %0b/%0b/%h want 1/%0b/%h", DmDone, DmErr, DmRdata, e.err, e.rdata); else passed++;
    @(posedge clk); #1;
    DmReq = 1'b0; DmWe = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk); #1;
    IfReq = 1'b1; IfAddr = 32'h300;
    exp_q.push_back('{model(32'h300), 1'b0});
    @(negedge clk);
    @(negedge clk);
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h300) $display("FAIL b2b_c1_fetch got %0b/%h want 1/300", MemReq, MemAddr); else passed++;
    @(posedge clk); #1;
    IfReq = 1'b0;
    DmReq = 1'b1; DmWe = 1'b0; DmAddr = 32'h5000; DmFunc3 = 3'b000;
    exp_q.push_back('{model(32'h5000), 1'b0});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (IfDone !== 1'b1 || IfRdata !== e.rdata || MemReq !== 1'b0) $display("FAIL b2b_c2 got %0b/%h/%0b want 1/%h/0", IfDone, IfRdata, MemReq, e.rdata); else passed++;
    @(negedge clk);
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h5000 || MemBe !== 4'hF) $display("FAIL b2b_c3_load got %0b/%h/%b want 1/5000/1111", MemReq, MemAddr, MemBe); else passed++;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (DmDone !== 1'b1 || DmRdata !== e.rdata) $display("FAIL b2b_c4 got %0b/%h want 1/%h", DmDone, DmRdata, e.rdata); else passed++;
    @(posedge clk); #1;
    DmReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    MemReady = 1'b0;
    @(posedge clk); #1;
    DmReq = 1'b1; DmWe = 1'b0; DmAddr = 32'h4000; DmFunc3 = 3'b010;
    @(negedge clk);
    @(negedge clk);
    checks++; if (MemReq !== 1'b1) $display("FAIL rmid_c1_req got %0b want 1", MemReq); else passed++;
    @(posedge clk); #1;
    reset = 1'b1; DmReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; MemReady = 1'b1;
    @(negedge clk);
    checks++; if (MemReq !== 1'b0 || MemBe !== 4'b0000 || MemAddr !== 32'h0) $display("FAIL rmid_bus got %0b/%b/%h want 0/0000/0", MemReq, MemBe, MemAddr); else passed++;
    checks++; if (DmRdata !== 32'h0 || IfRdata !== NOP_W) $display("FAIL rmid_rdata got %h/%h want 0/%h", DmRdata, IfRdata, NOP_W); else passed++;
    @(negedge clk);
    checks++; if ({IfDone, DmDone, DmErr} !== 3'b000 || MemReq !== 1'b0) $display("FAIL rmid_late_ready got %b/%0b want 000/0", {IfDone, DmDone, DmErr}, MemReq); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    IfReq = 1'b0; IfAddr = '0;
    DmReq = 1'b0; DmWe = 1'b0; DmAddr = '0;
    DmWdata = '0; DmFunc3 = 3'b000;
    MemReady = 1'b1;
    test_reset();
    test_fetch();
    test_priority();
    test_store_lanes();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_midflight();
    checks++; if (exp_q.size() != 0) $display("FAIL sb_drain got %0d want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max wait cycles for MemReady before abort (range 1..255).
REQ-003 SHALL have ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: IfReq in 1 fetch request; IfAddr in XLEN fetch address (PCF); IfRdata out XLEN fetched instruction; IfDone out 1 fetch-complete pulse.
REQ-006 SHALL have ports: DmReq in 1 load/store request; DmWe in 1 store; DmAddr in XLEN; DmWdata in XLEN; DmFunc3 in 3 access size (000 B, 001 H, 010 W; 1xx treated as its low-2-bit size); DmRdata out XLEN raw word; DmDone out 1 pulse; DmErr out 1 pulse.
REQ-007 SHALL have ports: MemReq out 1; MemWe out 1; MemAddr out XLEN word-aligned; MemWdata out XLEN lane-shifted; MemBe out 4; MemReady in 1; MemRdata in XLEN.
REQ-008 SHALL have port ArbStall out 1: (IfReq & ~IfDone) | (DmReq & ~DmDone), combinational, to hazard unit.

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, DATA; one memory transaction outstanding at most.
REQ-010 SHALL, in IDLE, go to DATA if DmReq, else FETCH if IfReq, else stay; data wins simultaneous requests.
REQ-011 SHALL register MemReq/MemWe/MemAddr/MemWdata/MemBe on the IDLE exit edge and hold them stable until MemReady sampled high or timeout.
REQ-012 SHALL, on MemReady high in FETCH/DATA, capture MemRdata into IfRdata/DmRdata, pulse the matching Done for exactly one cycle on the next cycle, deassert MemReq, return to IDLE.
REQ-013 SHALL achieve zero-wait latency of 2 cycles: request seen cycle 0, MemReq cycle 1, Done cycle 2; next transaction MemReq no earlier than cycle 3.
REQ-014 SHALL compute MemBe: B -> 0001<<addr[1:0]; H -> 0011<<{addr[1],0}; W -> 1111; MemWdata replicates byte/halfword to all lanes; loads drive MemBe 1111.
REQ-015 SHALL count wait cycles from MemReq assertion; after TIMEOUT cycles without MemReady, abort, pulse Done plus DmErr (data) with rdata 0; fetch timeout returns IfRdata 32'h00000013 (NOP).
REQ-016 SHALL complete a started transaction even if requester drops its Req mid-transaction; no Done suppression.
REQ-017 SHALL not re-issue a fetch while IfDone is high (same-cycle IfReq ignored), preventing duplicate fetch of an unchanged PC.

Reset
REQ-018 SHALL, on reset, force IDLE, wait counter 0, MemReq/MemWe 0, MemAddr/MemWdata 0, MemBe 0000, IfDone/DmDone/DmErr 0, IfRdata 32'h00000013, DmRdata 0.
REQ-019 SHALL abandon any in-flight transaction on reset; a late MemReady after reset SHALL be ignored.

Configuration
REQ-020 SHALL honour macro DMEM_MISALIGN_CHK_EN.
REQ-021 SHALL, when defined, detect H with addr[0]=1 or W with addr[1:0]!=0, issue no memory access, and pulse DmDone+DmErr 2 cycles after request.
REQ-022 SHALL, when undefined, ignore misalignment: access proceeds with addr[1:0] forced per REQ-014 and DmErr only from timeout.

Structure
REQ-023 SHALL place in shared package mem_arb_pkg: FSM state enum, func3 size constants, NOP constant, byte-enable function.
REQ-024 SHALL use one sub-module arb_timeout_ctr (load/enable/expire counter, width clog2(TIMEOUT+1)).

Verification
REQ-025 Bench: IfReq=1, IfAddr=0x100, MemReady tied 1, MemRdata=0x00500093 -> MemReq cycle 1, IfDone+IfRdata=0x00500093 cycle 2.
REQ-026 Bench: IfReq and DmReq (load 0x2000) same cycle -> DATA first, DmDone cycle 2, FETCH MemReq cycle 3, IfDone cycle 4.
REQ-027 Bench: store SB addr 0x2003 data 0xAB -> MemBe=1000, MemWdata=0xABABABAB, MemAddr=0x2000.
REQ-028 Bench: TIMEOUT=4, load, MemReady held 0 -> DmDone+DmErr pulse, DmRdata=0, MemReq low after 4 wait cycles.
REQ-029 Bench: reset asserted during DATA wait then MemReady=1 -> IDLE, no Done, outputs at reset values.
REQ-030 Bench (DMEM_MISALIGN_CHK_EN): SW at 0x2002 -> no MemReq, DmDone+DmErr cycle 2; without macro -> MemReq, MemBe=1111, MemAddr=0x2000.
